// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared constants and sizing helper for the I2C front end and cores.
// Revision : 1.0
// ============================================================================
package i2c_pkg;

    localparam logic c_BUS_IDLE   = 1'b1;
    localparam int   c_STAGES_DEF = 3;
    localparam int   c_FILT_DEF   = 4;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_glitch_filt.sv
`default_nettype none
// ============================================================================
// Module   : i2c_glitch_filt
// Brief    : One I2C line: synchroniser chain, spike filter and delayed copy.
// Revision : 1.0
// ============================================================================
module i2c_glitch_filt
    import i2c_pkg::*;
#(
    parameter int STAGES_G = c_STAGES_DEF,
    parameter int FILT_G   = c_FILT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic f_o,
    output logic fd_o
);

    localparam int              c_CW      = (clog2(FILT_G) > 0) ? clog2(FILT_G) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(FILT_G - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES_G-1:0] r_sync;
    logic            r_f;
    logic            r_fd;
    logic [c_CW-1:0] r_cnt;
    logic            w_sync;

    assign w_sync = r_sync[STAGES_G-1];

    // A new level is accepted only after FILT_G consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES_G{c_BUS_IDLE}};
            r_f    <= c_BUS_IDLE;
            r_fd   <= c_BUS_IDLE;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[STAGES_G-2:0], d_i};
            r_fd   <= r_f;
            if (w_sync == r_f) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_f   <= w_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign f_o  = r_f;
    assign fd_o = r_fd;

endmodule
`default_nettype wire

// File: rtl/i2c_sync_filt.sv
`default_nettype none
// ============================================================================
// Module   : i2c_sync_filt
// Brief    : SCL/SDA input conditioning with edge, START/STOP and busy detection.
// Revision : 1.0
// ============================================================================
module i2c_sync_filt
    import i2c_pkg::*;
#(
    parameter int STAGES_G   = c_STAGES_DEF,
    parameter int FILT_G     = c_FILT_DEF,
    parameter int BUS_FREE_G = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic busy_o
);

    logic w_scl_f;
    logic w_scl_fd;
    logic w_sda_f;
    logic w_sda_fd;
    logic w_scl_hold;
    logic w_timeout;
    logic r_busy;

    i2c_glitch_filt #(
        .STAGES_G (STAGES_G),
        .FILT_G   (FILT_G)
    ) u_scl_filt (
        .clk  (clk),
        .rst  (rst),
        .d_i  (scl_i),
        .f_o  (w_scl_f),
        .fd_o (w_scl_fd)
    );

    i2c_glitch_filt #(
        .STAGES_G (STAGES_G),
        .FILT_G   (FILT_G)
    ) u_sda_filt (
        .clk  (clk),
        .rst  (rst),
        .d_i  (sda_i),
        .f_o  (w_sda_f),
        .fd_o (w_sda_fd)
    );

    assign scl_o      = w_scl_f;
    assign sda_o      = w_sda_f;
    assign scl_rise_o = w_scl_f & ~w_scl_fd;
    assign scl_fall_o = ~w_scl_f & w_scl_fd;

    // SCL must be high in both this and the previous cycle, so an SDA edge that
    // coincides with an SCL edge is never taken as START/STOP.
    assign w_scl_hold = w_scl_f & w_scl_fd;
    assign start_o    = w_scl_hold & w_sda_fd & ~w_sda_f;
    assign stop_o     = w_scl_hold & ~w_sda_fd & w_sda_f;

    generate
        if (BUS_FREE_G > 0) begin : g_free_timer
            localparam int              c_FW       = (clog2(BUS_FREE_G) > 0) ? clog2(BUS_FREE_G) : 1;
            localparam logic [c_FW-1:0] c_FREE_MAX = c_FW'(BUS_FREE_G - 1);

            logic            w_lines_idle;
            logic [c_FW-1:0] r_free;

            assign w_lines_idle = w_scl_f & w_sda_f;

            always_ff @(posedge clk) begin
                if (rst || !w_lines_idle) begin
                    r_free <= '0;
                end else if (r_free != c_FREE_MAX) begin
                    r_free <= r_free + 1'b1;
                end
            end

            assign w_timeout = (r_free == c_FREE_MAX);
        end else begin : g_no_timer
            assign w_timeout = 1'b0;
        end
    endgenerate

    // START wins over a coincident timeout so a repeated START keeps the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else if (start_o) begin
            r_busy <= 1'b1;
        end else if (stop_o || w_timeout) begin
            r_busy <= 1'b0;
        end
    end

    assign busy_o = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_sync_filt.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_sync_filt
// Brief    : Scoreboard bench for i2c_sync_filt (STAGES 3, FILT 4, bus-free 50).
// Revision : 1.0
// ============================================================================
module tb_i2c_sync_filt;

    typedef struct {
        int       cyc;
        logic [3:0] vec;   // {scl_rise, scl_fall, start, stop}
    } evt_t;

    typedef struct {
        int   cyc;
        logic scl;
        logic sda;
        logic busy;
    } lvl_t;

    logic clk = 1'b0;
    logic rst;
    logic scl_i;
    logic sda_i;
    logic scl_o;
    logic sda_o;
    logic scl_rise_o;
    logic scl_fall_o;
    logic start_o;
    logic stop_o;
    logic busy_o;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    evt_t evq[$];
    lvl_t lvq[$];

    i2c_sync_filt #(
        .STAGES_G   (3),
        .FILT_G     (4),
        .BUS_FREE_G (50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .scl_rise_o (scl_rise_o),
        .scl_fall_o (scl_fall_o),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_evt(input int c, input logic [3:0] v);
        evt_t e;
        e.cyc = c;
        e.vec = v;
        evq.push_back(e);
    endtask

    task automatic exp_lvl(input int c, input logic s, input logic d, input logic b);
        lvl_t l;
        l.cyc  = c;
        l.scl  = s;
        l.sda  = d;
        l.busy = b;
        lvq.push_back(l);
    endtask

    // Monitor: strobes are matched against the event queue, levels against probes.
    always @(negedge clk) begin
        logic [3:0] v;
        v = {scl_rise_o, scl_fall_o, start_o, stop_o};
        if (cyc >= 1) begin
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_strobe cyc=%0d: got none, required %b", evq[0].cyc, evq[0].vec);
                void'(evq.pop_front());
            end
            if (v != 4'b0000) begin
                checks++;
                if (evq.size() > 0 && evq[0].cyc == cyc) begin
                    if (v !== evq[0].vec) begin
                        errors++;
                        $display("FAIL strobe cyc=%0d: got %b, required %b", cyc, v, evq[0].vec);
                    end
                    void'(evq.pop_front());
                end else begin
                    errors++;
                    $display("FAIL unexpected_strobe cyc=%0d: got %b, required 0000", cyc, v);
                end
            end
            for (int i = lvq.size() - 1; i >= 0; i--) begin
                if (lvq[i].cyc == cyc) begin
                    checks++;
                    if ({scl_o, sda_o, busy_o} !== {lvq[i].scl, lvq[i].sda, lvq[i].busy}) begin
                        errors++;
                        $display("FAIL levels cyc=%0d: got scl/sda/busy=%b%b%b, required %b%b%b",
                                 cyc, scl_o, sda_o, busy_o, lvq[i].scl, lvq[i].sda, lvq[i].busy);
                    end
                    lvq.delete(i);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst   = 1'b1;
        scl_i = 1'b1;
        sda_i = 1'b1;

        // Reset and idle bus
        exp_lvl(2, 1'b1, 1'b1, 1'b0);
        step(3);
        rst = 1'b0;
        n = cyc;
        exp_lvl(n + 5,  1'b1, 1'b1, 1'b0);
        exp_lvl(n + 20, 1'b1, 1'b1, 1'b0);
        step(22);

        // START, one SCL pulse, STOP
        n = cyc;
        sda_i = 1'b0;
        exp_lvl(n + 6, 1'b1, 1'b1, 1'b0);
        exp_evt(n + 7, 4'b0010);
        exp_lvl(n + 7, 1'b1, 1'b0, 1'b0);
        exp_lvl(n + 8, 1'b1, 1'b0, 1'b1);
        step(10);
        n = cyc;
        scl_i = 1'b0;
        exp_evt(n + 7, 4'b0100);
        exp_lvl(n + 8, 1'b0, 1'b0, 1'b1);
        step(10);
        scl_i = 1'b1;
        exp_evt(n + 17, 4'b1000);
        step(10);
        sda_i = 1'b1;
        exp_evt(n + 27, 4'b0001);
        exp_lvl(n + 27, 1'b1, 1'b1, 1'b1);
        exp_lvl(n + 28, 1'b1, 1'b1, 1'b0);
        step(40);

        // 3-cycle SDA glitch is swallowed
        n = cyc;
        sda_i = 1'b0;
        step(3);
        sda_i = 1'b1;
        exp_lvl(n + 7, 1'b1, 1'b1, 1'b0);
        exp_lvl(n + 9, 1'b1, 1'b1, 1'b0);
        step(15);

        // 4-cycle SDA pulse passes: START then STOP
        n = cyc;
        sda_i = 1'b0;
        step(4);
        sda_i = 1'b1;
        exp_evt(n + 7, 4'b0010);
        exp_lvl(n + 7,  1'b1, 1'b0, 1'b0);
        exp_lvl(n + 10, 1'b1, 1'b0, 1'b1);
        exp_evt(n + 11, 4'b0001);
        exp_lvl(n + 11, 1'b1, 1'b1, 1'b1);
        exp_lvl(n + 12, 1'b1, 1'b1, 1'b0);
        step(20);

        // SCL and SDA toggling together: edge strobes only
        n = cyc;
        scl_i = 1'b0;
        sda_i = 1'b0;
        exp_evt(n + 7, 4'b0100);
        exp_lvl(n + 8, 1'b0, 1'b0, 1'b0);
        step(10);
        scl_i = 1'b1;
        sda_i = 1'b1;
        exp_evt(n + 17, 4'b1000);
        exp_lvl(n + 18, 1'b1, 1'b1, 1'b0);
        step(20);

        // Bus-free timeout: busy clears 50 cycles after both lines are high
        n = cyc;
        sda_i = 1'b0;
        exp_evt(n + 7, 4'b0010);
        exp_lvl(n + 8, 1'b1, 1'b0, 1'b1);
        step(10);
        scl_i = 1'b0;
        exp_evt(n + 17, 4'b0100);
        step(10);
        sda_i = 1'b1;
        step(10);
        scl_i = 1'b1;
        exp_evt(n + 37, 4'b1000);
        exp_lvl(n + 37, 1'b1, 1'b1, 1'b1);
        exp_lvl(n + 86, 1'b1, 1'b1, 1'b1);
        exp_lvl(n + 87, 1'b1, 1'b1, 1'b0);
        step(60);

        // Repeated START in the timeout cycle keeps the bus busy
        n = cyc;
        sda_i = 1'b0;
        exp_evt(n + 7, 4'b0010);
        exp_lvl(n + 8, 1'b1, 1'b0, 1'b1);
        step(10);
        scl_i = 1'b0;
        exp_evt(n + 17, 4'b0100);
        step(10);
        sda_i = 1'b1;
        step(10);
        scl_i = 1'b1;
        exp_evt(n + 37, 4'b1000);
        step(49);
        sda_i = 1'b0;
        exp_evt(n + 86, 4'b0010);
        exp_lvl(n + 86, 1'b1, 1'b0, 1'b1);
        exp_lvl(n + 87, 1'b1, 1'b0, 1'b1);
        exp_lvl(n + 88, 1'b1, 1'b0, 1'b1);
        step(11);

        // Reset mid-byte with SCL low and bus busy
        scl_i = 1'b0;
        exp_evt(n + 97, 4'b0100);
        exp_lvl(n + 98, 1'b0, 1'b0, 1'b1);
        step(10);
        rst   = 1'b1;
        scl_i = 1'b1;
        sda_i = 1'b1;
        exp_lvl(n + 101, 1'b1, 1'b1, 1'b0);
        step(2);
        rst = 1'b0;
        exp_lvl(n + 112, 1'b1, 1'b1, 1'b0);
        step(15);

        while (evq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_strobe cyc=%0d: got none, required %b", evq[0].cyc, evq[0].vec);
            void'(evq.pop_front());
        end
        while (lvq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_probe cyc=%0d: got none, required scl/sda/busy=%b%b%b",
                     lvq[0].cyc, lvq[0].scl, lvq[0].sda, lvq[0].busy);
            void'(lvq.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
